// File: rtl/mult_seq32.sv
// mult_seq32 -- sequential shift-and-add unsigned multiplier, N x N -> 2N.
// One operand pair is processed at a time with a valid/ready handshake on
// both sides; the product is held under backpressure until it is taken.
// Optional build macro: MULT_SEQ_EARLY_EXIT_EN -- when defined, a zero
// operand skips the iteration and the (zero) product is offered one cycle
// after the accept. Intended for N >= 2.

// N-bit ripple-carry adder built from a chain of full adders.
module mult_seq32_ripple_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] ina,
    input  logic [W-1:0] inb,
    input  logic         ci,
    output logic         co,
    output logic [W-1:0] out
);

    logic [W:0] w_carry;

    assign w_carry[0] = ci;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_fa
            assign out[gi]         = ina[gi] ^ inb[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (ina[gi] & inb[gi]) |
                                     (w_carry[gi] & (ina[gi] ^ inb[gi]));
        end
    endgenerate

    assign co = w_carry[W];

endmodule

module mult_seq32 #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_product,
    output logic             busy
);

    // Iteration counter only needs to reach N-1; it is cleared on accept.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_a;        // latched multiplicand
    logic [N-1:0]   r_hi;       // upper half of the partial product
    logic [N-1:0]   r_lo;       // multiplier bits still to consume / lower product half
    logic [CW-1:0]  r_count;

    logic [N-1:0]   w_addend;
    logic [N-1:0]   w_sum;
    logic           w_co;

    // Add A into the upper half only when the current multiplier bit is set.
    assign w_addend = r_lo[0] ? r_a : '0;

    // The single adder used by the datapath; its carry-out becomes the new
    // top bit of HI after the right shift, so no product bit is ever lost.
    mult_seq32_ripple_adder #(
        .W (N)
    ) u_adder (
        .ina (r_hi),
        .inb (w_addend),
        .ci  (1'b0),
        .co  (w_co),
        .out (w_sum)
    );

    // Control FSM and shift-add datapath; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_hi    <= '0;
                        r_count <= '0;
`ifdef MULT_SEQ_EARLY_EXIT_EN
                        if ((in_a == '0) || (in_b == '0)) begin
                            // Product is trivially zero; skip the iteration.
                            r_lo    <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_lo    <= in_b;
                            r_state <= S_RUN;
                        end
`else
                        r_lo    <= in_b;
                        r_state <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    // {HI,LO} <= {co, sum, LO} >> 1
                    r_hi    <= {w_co, w_sum[N-1:1]};
                    r_lo    <= {w_sum[0], r_lo[N-1:1]};
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(N - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Hold the product until the consumer takes it. The
                    // transfer cycle itself never accepts a new pair because
                    // in_ready is low outside IDLE.
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign out_product = {r_hi, r_lo};

endmodule

// File: tb/tb_mult_seq32.sv
// Testbench for mult_seq32: scenario tasks plus a randomized run, all
// checked against plain-arithmetic expectations for product and latency.
module tb_mult_seq32;

    localparam int N     = 32;
    localparam int LIMIT = 200;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_a;
    logic [N-1:0]    in_b;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  out_product;
    logic            busy;

    int vectors;
    int miscompares;

    mult_seq32 #(
        .N (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width unsigned product.
    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        return (2*N)'(a) * (2*N)'(b);
    endfunction

    // Reference latency, counting the accept edge as cycle 1.
    function automatic int exp_lat(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MULT_SEQ_EARLY_EXIT_EN
        if ((a == 0) || (b == 0)) return 1;
`endif
        return N + 1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one pair at a negedge while idle; returns at the negedge after the accept edge.
    task automatic offer(input logic [N-1:0] a, input logic [N-1:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat counts edges from the accept edge inclusive.
    task automatic wait_valid(output int lat, output bit leak);
        lat  = 1;
        leak = 1'b0;
        while (!out_valid && lat < LIMIT) begin
            if (in_ready) leak = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, expected 1 0 0",
                     in_ready, out_valid, busy);
        end
        vectors++;
        if (out_product !== '0) begin
            miscompares++;
            $display("FAIL reset_product: got %h expected 0", out_product);
        end
        $display("txn reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
    endtask

    task automatic test_basic();
        int lat;
        bit leak;
        do_reset();
        out_ready = 1'b1;
        offer(32'd3, 32'd5);
        wait_valid(lat, leak);
        $display("txn basic: a=3 b=5 product=%0d latency=%0d", out_product, lat);
        vectors++;
        if (lat !== exp_lat(32'd3, 32'd5)) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat(32'd3, 32'd5));
        end
        vectors++;
        if (out_product !== ref_mul(32'd3, 32'd5)) begin
            miscompares++;
            $display("FAIL basic_product: got %0d expected 15", out_product);
        end
        vectors++;
        if (leak !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_ready_busy: in_ready leak=%b busy=%b, expected 0 1", leak, busy);
        end
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_max();
        int lat;
        bit leak;
        logic [N-1:0] m;
        m = '1;
        do_reset();
        out_ready = 1'b1;
        offer(m, m);
        wait_valid(lat, leak);
        $display("txn max: a=%h b=%h product=%h latency=%0d", m, m, out_product, lat);
        vectors++;
        if (out_product !== 64'hFFFF_FFFE_0000_0001) begin
            miscompares++;
            $display("FAIL max_product: got %h expected fffffffe00000001", out_product);
        end
        vectors++;
        if (lat !== exp_lat(m, m)) begin
            miscompares++;
            $display("FAIL max_latency: got %0d expected %0d", lat, exp_lat(m, m));
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        bit leak;
        int valid_cnt;
        int xfers;
        bit held;
        logic [2*N-1:0] exp;
        do_reset();
        out_ready = 1'b0;
        exp = ref_mul(32'h1234_5678, 32'h9ABC_DEF0);
        offer(32'h1234_5678, 32'h9ABC_DEF0);
        wait_valid(lat, leak);
        valid_cnt = 0;
        xfers     = 0;
        held      = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                valid_cnt++;
                if (out_product !== exp) held = 1'b0;
            end
            if (valid_cnt == 11) out_ready = 1'b1;
            if (out_valid && out_ready) xfers++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        $display("txn backpressure: product=%h valid_cycles=%0d transfers=%0d", exp, valid_cnt, xfers);
        vectors++;
        if (valid_cnt !== 11) begin
            miscompares++;
            $display("FAIL bp_valid_cycles: got %0d expected 11", valid_cnt);
        end
        vectors++;
        if (xfers !== 1) begin
            miscompares++;
            $display("FAIL bp_transfers: got %0d expected 1", xfers);
        end
        vectors++;
        if (held !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_product_stable: product changed or wrong, expected %h", exp);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit leak;
        bit seen;
        do_reset();
        out_ready = 1'b1;
        offer(32'd100, 32'd200);
        repeat (16) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_running: busy=%b out_valid=%b, expected 1 0", busy, out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_idle: in_ready=%b busy=%b out_valid=%b, expected 1 0 0",
                     in_ready, busy, out_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_no_valid: out_valid seen=%b expected 0", seen);
        end
        offer(32'd7, 32'd6);
        wait_valid(lat, leak);
        $display("txn reset_mid: a=7 b=6 product=%0d latency=%0d", out_product, lat);
        vectors++;
        if (out_product !== 64'd42 || lat !== exp_lat(32'd7, 32'd6)) begin
            miscompares++;
            $display("FAIL midrst_after: product=%0d latency=%0d, expected 42 %0d",
                     out_product, lat, exp_lat(32'd7, 32'd6));
        end
        @(negedge clk);
    endtask

    task automatic test_zero();
        int lat;
        bit leak;
        do_reset();
        out_ready = 1'b1;
        offer(32'd0, 32'h1234);
        wait_valid(lat, leak);
        $display("txn zero: a=0 b=1234 product=%h latency=%0d", out_product, lat);
        vectors++;
        if (out_product !== '0) begin
            miscompares++;
            $display("FAIL zero_product: got %h expected 0", out_product);
        end
        vectors++;
        if (lat !== exp_lat(32'd0, 32'h1234)) begin
            miscompares++;
            $display("FAIL zero_latency: got %0d expected %0d", lat, exp_lat(32'd0, 32'h1234));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        bit leak;
        do_reset();
        out_ready = 1'b1;
        in_a      = 32'd2;
        in_b      = 32'd3;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_a = 32'h0001_0000;
        in_b = 32'h0001_0000;
        wait_valid(lat, leak);
        $display("txn b2b_first: a=2 b=3 product=%0d latency=%0d", out_product, lat);
        vectors++;
        if (out_product !== 64'd6 || lat !== exp_lat(32'd2, 32'd3) || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: product=%0d latency=%0d in_ready=%b, expected 6 %0d 0",
                     out_product, lat, in_ready, exp_lat(32'd2, 32'd3));
        end
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: in_ready=%b busy=%b out_valid=%b, expected 1 0 0",
                     in_ready, busy, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat, leak);
        $display("txn b2b_second: a=10000 b=10000 product=%h latency=%0d", out_product, lat);
        vectors++;
        if (out_product !== 64'h1_0000_0000 ||
            lat !== exp_lat(32'h0001_0000, 32'h0001_0000)) begin
            miscompares++;
            $display("FAIL b2b_second: product=%h latency=%0d, expected 100000000 %0d",
                     out_product, lat, exp_lat(32'h0001_0000, 32'h0001_0000));
        end
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_release: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_random();
        int lat;
        bit leak;
        int d;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2*N-1:0] exp;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 8 == 5) a = '0;
            if (i % 8 == 6) b = 32'd1;
            exp = ref_mul(a, b);
            out_ready = ($urandom_range(0, 1) == 1);
            offer(a, b);
            wait_valid(lat, leak);
            $display("txn random %0d: a=%h b=%h product=%h latency=%0d", i, a, b, out_product, lat);
            vectors++;
            if (out_product !== exp || lat !== exp_lat(a, b) || leak !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_txn%0d: product=%h latency=%0d leak=%b, expected %h %0d 0",
                         i, out_product, lat, leak, exp, exp_lat(a, b));
            end
            if (!out_ready) begin
                d = $urandom_range(1, 3);
                repeat (d) @(negedge clk);
                vectors++;
                if (out_valid !== 1'b1 || out_product !== exp) begin
                    miscompares++;
                    $display("FAIL rand_hold%0d: out_valid=%b product=%h, expected 1 %h",
                             i, out_valid, out_product, exp);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        out_ready   = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
